lbp_mem_arb: RTL and testbench

- Shares one single-port gray-image read memory and one LBP result write port between NUM_REQ LBP engines.
- Each engine splits the frame (e.g. top/bottom halves).
- Read side: round-robin arbitration, per-requester tagged return of read data.
- Write side: round-robin arbitration, registered LBP output port.
- Aggregates per-engine done flags into a sticky frame-level finish.

---
 rtl/lbp_mem_arb_if.sv | 30 +++
 rtl/lbp_mem_arb.sv | 149 ++++++++++++++
 tb/tb_lbp_mem_arb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_mem_arb_if.sv
// Engine-side bus of the LBP memory arbiter: read and write request/grant
// channels, tagged read return and per-engine done flags.
interface lbp_mem_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int AW      = 14,
   parameter int DW      = 8
);
   logic [NUM_REQ-1:0]    rd_req;
   logic [NUM_REQ*AW-1:0] rd_addr;
   logic [NUM_REQ-1:0]    rd_gnt;
   logic [NUM_REQ-1:0]    rd_vld;
   logic [DW-1:0]         rd_data;
   logic [NUM_REQ-1:0]    wr_req;
   logic [NUM_REQ*AW-1:0] wr_addr;
   logic [NUM_REQ*DW-1:0] wr_data;
   logic [NUM_REQ-1:0]    wr_gnt;
   logic [NUM_REQ-1:0]    eng_done;

   // The engines drive requests and observe grants / returned data.
   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, eng_done,
      input  rd_gnt, rd_vld, rd_data, wr_gnt
   );

   // The arbiter observes requests and drives grants / returned data.
   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, eng_done,
      output rd_gnt, rd_vld, rd_data, wr_gnt
   );
endinterface

// File: rtl/lbp_mem_arb.sv
// Shares one gray-image read memory and one LBP result write port between
// NUM_REQ LBP engines. Independent round-robin arbiters on the read and write
// sides, tagged read return, and a sticky frame-level finish flag.
module lbp_mem_arb #(
   parameter int NUM_REQ = 2,
   parameter int AW      = 14,
   parameter int DW      = 8,
   parameter int RD_LAT  = 1
) (
   input  logic          clk,
   input  logic          reset,
   lbp_mem_arb_if.slave  eng,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          lbp_valid,
   output logic [AW-1:0] lbp_addr,
   output logic [DW-1:0] lbp_data,
   output logic          finish
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PW-1:0] PTR_INIT = PW'(NUM_REQ - 1);

   // Round-robin pick: first asserted request after ptr, wrapping.
   function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [PW-1:0]      ptr);
      logic found;
      int   idx;
      rr_pick = '0;
      found   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            rr_pick[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   endfunction

   // One-hot to index.
   function automatic logic [PW-1:0] oh_enc(input logic [NUM_REQ-1:0] oh);
      oh_enc = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) oh_enc = PW'(i);
      end
   endfunction

   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [NUM_REQ-1:0] rd_gnt_c;
   logic [NUM_REQ-1:0] wr_gnt_c;
   logic [PW-1:0]      rd_sel;
   logic [PW-1:0]      wr_sel;
   logic               rd_any;
   logic               wr_any;
   logic [RD_LAT:0]    tag_vld;
   logic [PW-1:0]      tag_idx [RD_LAT+1];
   logic [NUM_REQ-1:0] rd_vld_c;
   logic [NUM_REQ-1:0] done_lat;

   assign rd_gnt_c     = rr_pick(eng.rd_req, rd_ptr);
   assign wr_gnt_c     = rr_pick(eng.wr_req, wr_ptr);
   assign rd_sel       = oh_enc(rd_gnt_c);
   assign wr_sel       = oh_enc(wr_gnt_c);
   assign rd_any       = |rd_gnt_c;
   assign wr_any       = |wr_gnt_c;

   assign eng.rd_gnt   = rd_gnt_c;
   assign eng.wr_gnt   = wr_gnt_c;
   assign eng.rd_vld   = rd_vld_c;
   // Data is broadcast; each engine qualifies it with its rd_vld bit.
   assign eng.rd_data  = mem_rdata;

   // Read issue: register the winning address and strobe, advance the pointer.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= PTR_INIT;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_rd <= rd_any;
         if (rd_any) begin
            rd_ptr   <= rd_sel;
            mem_addr <= eng.rd_addr[int'(rd_sel)*AW +: AW];
         end
      end
   end

   // Tag pipeline: stage k is valid in cycle grant+1+k, so the last stage
   // lines up with the cycle mem_rdata is valid.
   // NOTE: the tag index array is reset as well, not just the valid bits; it
   // is a handful of flops of control state, and clearing it keeps a reset
   // mid-read from ever surfacing a stale owner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld <= '0;
         for (int i = 0; i <= RD_LAT; i++) tag_idx[i] <= '0;
      end else begin
         tag_vld    <= {tag_vld[RD_LAT-1:0], rd_any};
         tag_idx[0] <= rd_sel;
         for (int i = 1; i <= RD_LAT; i++) tag_idx[i] <= tag_idx[i-1];
      end
   end

   // Decode the last tag stage into the owning engine's rd_vld.
   // NOTE: the default assignment first keeps this purely combinational; a
   // missing default on the not-valid path would infer a latch.
   always_comb begin
      rd_vld_c = '0;
      if (tag_vld[RD_LAT]) rd_vld_c[tag_idx[RD_LAT]] = 1'b1;
   end

   // Write path: registered LBP output port; data returns to zero when idle,
   // the address holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= PTR_INIT;
         lbp_valid <= 1'b0;
         lbp_addr  <= '0;
         lbp_data  <= '0;
      end else begin
         lbp_valid <= wr_any;
         if (wr_any) begin
            wr_ptr   <= wr_sel;
            lbp_addr <= eng.wr_addr[int'(wr_sel)*AW +: AW];
            lbp_data <= eng.wr_data[int'(wr_sel)*DW +: DW];
         end else begin
            lbp_data <= '0;
         end
      end
   end

   // Done aggregation: sticky per-engine latches, finish once everything has
   // drained (no read in flight, no write pending or being output).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_lat <= '0;
         finish   <= 1'b0;
      end else begin
         done_lat <= done_lat | eng.eng_done;
         if (&done_lat && !(|tag_vld) && !lbp_valid && !(|eng.wr_req))
            finish <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lbp_mem_arb.sv
// Directed bench for lbp_mem_arb: a per-cycle vector table for the read and
// write arbiters, plus hand-written sequences for reset mid-read, RD_LAT=3
// return timing and the finish flag. Two DUTs (RD_LAT=1 and RD_LAT=3) share
// the same engine-side stimulus.
module tb_lbp_mem_arb;

   localparam int NUM_REQ = 2;
   localparam int AW      = 14;
   localparam int DW      = 8;
   localparam int NVEC    = 25;

   logic                  clk;
   logic                  reset;
   logic [NUM_REQ-1:0]    rd_req;
   logic [NUM_REQ*AW-1:0] rd_addr;
   logic [NUM_REQ-1:0]    wr_req;
   logic [NUM_REQ*AW-1:0] wr_addr;
   logic [NUM_REQ*DW-1:0] wr_data;
   logic [NUM_REQ-1:0]    eng_done;
   logic [DW-1:0]         mem_rdata;

   logic          mem_rd1, mem_rd3, lbp_valid1, lbp_valid3, finish1, finish3;
   logic [AW-1:0] mem_addr1, mem_addr3, lbp_addr1, lbp_addr3;
   logic [DW-1:0] lbp_data1, lbp_data3;

   int checks = 0;
   int errors = 0;

   lbp_mem_arb_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) if1 ();
   lbp_mem_arb_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) if3 ();

   assign if1.rd_req   = rd_req;
   assign if1.rd_addr  = rd_addr;
   assign if1.wr_req   = wr_req;
   assign if1.wr_addr  = wr_addr;
   assign if1.wr_data  = wr_data;
   assign if1.eng_done = eng_done;
   assign if3.rd_req   = rd_req;
   assign if3.rd_addr  = rd_addr;
   assign if3.wr_req   = wr_req;
   assign if3.wr_addr  = wr_addr;
   assign if3.wr_data  = wr_data;
   assign if3.eng_done = eng_done;

   lbp_mem_arb #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .eng       (if1.slave),
      .mem_rd    (mem_rd1),
      .mem_addr  (mem_addr1),
      .mem_rdata (mem_rdata),
      .lbp_valid (lbp_valid1),
      .lbp_addr  (lbp_addr1),
      .lbp_data  (lbp_data1),
      .finish    (finish1)
   );

   lbp_mem_arb #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .eng       (if3.slave),
      .mem_rd    (mem_rd3),
      .mem_addr  (mem_addr3),
      .mem_rdata (mem_rdata),
      .lbp_valid (lbp_valid3),
      .lbp_addr  (lbp_addr3),
      .lbp_data  (lbp_data3),
      .finish    (finish3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  rd_req;
      logic [13:0] a0;
      logic [13:0] a1;
      logic [1:0]  wr_req;
      logic [1:0]  e_rd_gnt;
      logic [1:0]  e_rd_vld;
      logic        e_mem_rd;
      logic [13:0] e_mem_addr;
      logic [1:0]  e_wr_gnt;
      logic        e_lbp_valid;
      logic [13:0] e_lbp_addr;
      logic [7:0]  e_lbp_data;
   } vec_t;

   vec_t       vecs [NVEC];
   logic [1:0] exp_g [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] g_at(input int k);
      return (k >= 0 && k < 10) ? exp_g[k] : 2'b00;
   endfunction

   initial begin
      //            rd   a0        a1        wr     rgnt  rvld  mrd   maddr     wgnt  lv    laddr     ldata
      vecs[0]  = '{2'b00, 14'h0000, 14'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 14'h0000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[1]  = '{2'b01, 14'h0081, 14'h0000, 2'b00, 2'b01, 2'b00, 1'b0, 14'h0000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[2]  = '{2'b00, 14'h0081, 14'h0000, 2'b00, 2'b00, 2'b00, 1'b1, 14'h0081, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[3]  = '{2'b00, 14'h0081, 14'h0000, 2'b00, 2'b00, 2'b01, 1'b0, 14'h0081, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[4]  = '{2'b10, 14'h0000, 14'h2000, 2'b00, 2'b10, 2'b00, 1'b0, 14'h0081, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[5]  = '{2'b11, 14'h0000, 14'h2000, 2'b00, 2'b01, 2'b00, 1'b1, 14'h2000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[6]  = '{2'b11, 14'h0000, 14'h2000, 2'b00, 2'b10, 2'b10, 1'b1, 14'h0000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[7]  = '{2'b11, 14'h0000, 14'h2000, 2'b00, 2'b01, 2'b01, 1'b1, 14'h2000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[8]  = '{2'b11, 14'h0000, 14'h2000, 2'b00, 2'b10, 2'b10, 1'b1, 14'h0000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[9]  = '{2'b11, 14'h0000, 14'h2000, 2'b00, 2'b01, 2'b01, 1'b1, 14'h2000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[10] = '{2'b11, 14'h0000, 14'h2000, 2'b00, 2'b10, 2'b10, 1'b1, 14'h0000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[11] = '{2'b00, 14'h0000, 14'h2000, 2'b00, 2'b00, 2'b01, 1'b1, 14'h2000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[12] = '{2'b00, 14'h0000, 14'h2000, 2'b00, 2'b00, 2'b10, 1'b0, 14'h2000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[13] = '{2'b00, 14'h0000, 14'h2000, 2'b00, 2'b00, 2'b00, 1'b0, 14'h2000, 2'b00, 1'b0, 14'h0000, 8'h00};
      vecs[14] = '{2'b00, 14'h0000, 14'h2000, 2'b11, 2'b00, 2'b00, 1'b0, 14'h2000, 2'b01, 1'b0, 14'h0000, 8'h00};
      vecs[15] = '{2'b00, 14'h0000, 14'h2000, 2'b10, 2'b00, 2'b00, 1'b0, 14'h2000, 2'b10, 1'b1, 14'h0081, 8'hA5};
      vecs[16] = '{2'b00, 14'h0000, 14'h2000, 2'b00, 2'b00, 2'b00, 1'b0, 14'h2000, 2'b00, 1'b1, 14'h2081, 8'h3C};
      vecs[17] = '{2'b00, 14'h0000, 14'h2000, 2'b00, 2'b00, 2'b00, 1'b0, 14'h2000, 2'b00, 1'b0, 14'h2081, 8'h00};
      vecs[18] = '{2'b01, 14'h0042, 14'h2000, 2'b01, 2'b01, 2'b00, 1'b0, 14'h2000, 2'b01, 1'b0, 14'h2081, 8'h00};
      vecs[19] = '{2'b00, 14'h0042, 14'h2000, 2'b00, 2'b00, 2'b00, 1'b1, 14'h0042, 2'b00, 1'b1, 14'h0081, 8'hA5};
      vecs[20] = '{2'b00, 14'h0042, 14'h2000, 2'b00, 2'b00, 2'b01, 1'b0, 14'h0042, 2'b00, 1'b0, 14'h0081, 8'h00};
      vecs[21] = '{2'b11, 14'h0011, 14'h2022, 2'b00, 2'b10, 2'b00, 1'b0, 14'h0042, 2'b00, 1'b0, 14'h0081, 8'h00};
      vecs[22] = '{2'b00, 14'h0011, 14'h2022, 2'b00, 2'b00, 2'b00, 1'b1, 14'h2022, 2'b00, 1'b0, 14'h0081, 8'h00};
      vecs[23] = '{2'b00, 14'h0011, 14'h2022, 2'b00, 2'b00, 2'b10, 1'b0, 14'h2022, 2'b00, 1'b0, 14'h0081, 8'h00};
      vecs[24] = '{2'b00, 14'h0011, 14'h2022, 2'b00, 2'b00, 2'b00, 1'b0, 14'h2022, 2'b00, 1'b0, 14'h0081, 8'h00};

      // Expected read grants after reset: contention, engine 1 alone, contention.
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      for (int k = 4; k < 10; k++) exp_g[k] = 2'b00;

      // Reset state
      reset     = 1'b1;
      rd_req    = '0;
      wr_req    = '0;
      eng_done  = '0;
      rd_addr   = '0;
      wr_addr   = {14'h2081, 14'h0081};
      wr_data   = {8'h3C, 8'hA5};
      mem_rdata = '0;
      #1;
      check("reset rd_gnt",    32'(if1.rd_gnt), 32'h0);
      check("reset wr_gnt",    32'(if1.wr_gnt), 32'h0);
      check("reset rd_vld",    32'(if1.rd_vld), 32'h0);
      check("reset mem_rd",    32'(mem_rd1),    32'h0);
      check("reset mem_addr",  32'(mem_addr1),  32'h0);
      check("reset lbp_valid", 32'(lbp_valid1), 32'h0);
      check("reset lbp_addr",  32'(lbp_addr1),  32'h0);
      check("reset lbp_data",  32'(lbp_data1),  32'h0);
      check("reset finish",    32'(finish1),    32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Vector table: one row per cycle.
      for (int i = 0; i < NVEC; i++) begin
         logic [7:0] exp_rd;
         @(negedge clk);
         rd_req    = vecs[i].rd_req;
         rd_addr   = {vecs[i].a1, vecs[i].a0};
         wr_req    = vecs[i].wr_req;
         exp_rd    = 8'(i * 29 + 7);
         mem_rdata = exp_rd;
         #1;
         check($sformatf("row%0d rd_gnt", i),    32'(if1.rd_gnt), 32'(vecs[i].e_rd_gnt));
         check($sformatf("row%0d rd_vld", i),    32'(if1.rd_vld), 32'(vecs[i].e_rd_vld));
         check($sformatf("row%0d rd_data", i),   32'(if1.rd_data), 32'(exp_rd));
         check($sformatf("row%0d mem_rd", i),    32'(mem_rd1),    32'(vecs[i].e_mem_rd));
         check($sformatf("row%0d mem_addr", i),  32'(mem_addr1),  32'(vecs[i].e_mem_addr));
         check($sformatf("row%0d wr_gnt", i),    32'(if1.wr_gnt), 32'(vecs[i].e_wr_gnt));
         check($sformatf("row%0d lbp_valid", i), 32'(lbp_valid1), 32'(vecs[i].e_lbp_valid));
         check($sformatf("row%0d lbp_addr", i),  32'(lbp_addr1),  32'(vecs[i].e_lbp_addr));
         check($sformatf("row%0d lbp_data", i),  32'(lbp_data1),  32'(vecs[i].e_lbp_data));
         check($sformatf("row%0d finish", i),    32'(finish1),    32'h0);
         check($sformatf("row%0d lat3 rd_gnt", i),   32'(if3.rd_gnt), 32'(vecs[i].e_rd_gnt));
         check($sformatf("row%0d lat3 mem_addr", i), 32'(mem_addr3),  32'(vecs[i].e_mem_addr));
      end

      // Reset mid-read: three read grants and one write grant, then reset.
      rd_addr = {14'h2100, 14'h0100};
      for (int m = 0; m < 3; m++) begin
         @(negedge clk);
         rd_req = 2'b11;
         wr_req = (m == 0) ? 2'b01 : 2'b00;
         #1;
         if (m > 0) check($sformatf("midrd m%0d mem_rd", m), 32'(mem_rd1), 32'h1);
         if (m == 1) check("midrd lbp_valid", 32'(lbp_valid1), 32'h1);
      end
      #1;
      reset  = 1'b1;
      rd_req = 2'b00;
      #1;
      check("midrd rst mem_rd",     32'(mem_rd1),    32'h0);
      check("midrd rst mem_addr",   32'(mem_addr1),  32'h0);
      check("midrd rst rd_vld",     32'(if1.rd_vld), 32'h0);
      check("midrd rst lat3 rd_vld", 32'(if3.rd_vld), 32'h0);
      check("midrd rst lbp_valid",  32'(lbp_valid1), 32'h0);
      check("midrd rst lbp_addr",   32'(lbp_addr1),  32'h0);
      check("midrd rst lbp_data",   32'(lbp_data1),  32'h0);
      check("midrd rst finish",     32'(finish1),    32'h0);
      @(negedge clk);

      // After release: pointer reset, pointer memory and RD_LAT=1/3 return timing.
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         reset  = 1'b0;
         rd_req = (k == 0 || k == 2 || k == 3) ? 2'b11 : (k == 1) ? 2'b10 : 2'b00;
         #1;
         check($sformatf("post k%0d rd_gnt", k),      32'(if1.rd_gnt), 32'(g_at(k)));
         check($sformatf("post k%0d lat3 rd_gnt", k), 32'(if3.rd_gnt), 32'(g_at(k)));
         check($sformatf("post k%0d rd_vld", k),      32'(if1.rd_vld), 32'(g_at(k - 2)));
         check($sformatf("post k%0d lat3 rd_vld", k), 32'(if3.rd_vld), 32'(g_at(k - 4)));
         check($sformatf("post k%0d lat3 mem_rd", k), 32'(mem_rd3),    32'(g_at(k - 1) != 2'b00));
      end

      // Finish: engine 0 done at k=10, read by engine 1 at k=19, engine 1
      // done at k=20; one more read after finish.
      for (int k = 0; k <= 30; k++) begin
         logic [1:0] e_vld1;
         logic [1:0] e_vld3;
         @(negedge clk);
         eng_done = (k == 10) ? 2'b01 : (k == 20) ? 2'b10 : 2'b00;
         rd_req   = (k == 19) ? 2'b10 : (k == 25) ? 2'b01 : 2'b00;
         e_vld1   = (k == 21) ? 2'b10 : (k == 27) ? 2'b01 : 2'b00;
         e_vld3   = (k == 23) ? 2'b10 : (k == 29) ? 2'b01 : 2'b00;
         #1;
         check($sformatf("fin k%0d rd_gnt", k),      32'(if1.rd_gnt), 32'(rd_req));
         check($sformatf("fin k%0d rd_vld", k),      32'(if1.rd_vld), 32'(e_vld1));
         check($sformatf("fin k%0d lat3 rd_vld", k), 32'(if3.rd_vld), 32'(e_vld3));
         check($sformatf("fin k%0d finish", k),      32'(finish1),    32'(k >= 23));
         check($sformatf("fin k%0d lat3 finish", k), 32'(finish3),    32'(k >= 25));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
